// File: rtl/vram_slot_scheduler.sv
// VRAM access slot arbiter: display/sprite reservations, CPU and command-engine
// toggle-handshake requests, with a starvation boost for command accesses.
module vram_slot_scheduler #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic       CLK21M,
  input  logic       RESET_N,
  input  logic [1:0] DOTSTATE,
  input  logic       DISP_RSV,
  input  logic       SPRT_RSV,
  input  logic       CPU_WR_REQ,
  input  logic       CPU_RD_REQ,
  input  logic       CMD_ACTIVE,
  input  logic       CMD_WR_REQ,
  input  logic       CMD_RD_REQ,
  output logic       CPU_WR_ACK,
  output logic       CPU_RD_ACK,
  output logic       CMD_WR_ACK,
  output logic       CMD_RD_ACK,
  output logic [2:0] GRANT,
  output logic       GRANT_VALID,
  output logic       CMD_BOOST,
  output logic [3:0] STARVE_CNT
);
  typedef enum logic {NORMAL, BOOST} state_t;

  localparam logic [2:0] G_IDLE = 3'd0, G_DRAW = 3'd1, G_CPUW = 3'd2, G_CPUR = 3'd3,
                         G_SPRT = 3'd4, G_VDPW = 3'd5, G_VDPR = 3'd6, G_VDPS = 3'd7;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  state_t     state, state_nxt;
  logic [2:0] grant_nxt;
  logic [3:0] cnt_nxt;
  logic       slot, cpu_wr_p, cpu_rd_p, cmd_wr_p, cmd_rd_p, cmd_pend, cmd_grant;

  assign slot     = (DOTSTATE == 2'b10);
  assign cpu_wr_p = CPU_WR_REQ ^ CPU_WR_ACK;
  assign cpu_rd_p = CPU_RD_REQ ^ CPU_RD_ACK;
  // Command toggles stay outstanding while the engine is stopped, but do not compete.
  assign cmd_wr_p = CMD_ACTIVE & (CMD_WR_REQ ^ CMD_WR_ACK);
  assign cmd_rd_p = CMD_ACTIVE & (CMD_RD_REQ ^ CMD_RD_ACK);
  assign cmd_pend = cmd_wr_p | cmd_rd_p;
  assign CMD_BOOST = (state == BOOST);

  always_comb begin
    grant_nxt = G_IDLE;
    if (DISP_RSV)                        grant_nxt = G_DRAW;
    else if (SPRT_RSV)                   grant_nxt = G_SPRT;
    else if (state == BOOST && cmd_wr_p) grant_nxt = G_VDPW;
    else if (state == BOOST && cmd_rd_p) grant_nxt = G_VDPR;
    else if (cpu_wr_p)                   grant_nxt = G_CPUW;
    else if (cpu_rd_p)                   grant_nxt = G_CPUR;
    else if (cmd_wr_p)                   grant_nxt = G_VDPW;
    else if (cmd_rd_p)                   grant_nxt = G_VDPR;
    else if (CMD_ACTIVE)                 grant_nxt = G_VDPS;
  end

  assign cmd_grant = (grant_nxt == G_VDPW) || (grant_nxt == G_VDPR);

  always_comb begin
    cnt_nxt   = 4'd0;
    state_nxt = NORMAL;
    if (!cmd_grant && cmd_pend) begin
      cnt_nxt   = (STARVE_CNT >= LIM) ? LIM : STARVE_CNT + 4'd1;
      state_nxt = (cnt_nxt == LIM) ? BOOST : state;
    end
  end

  always_ff @(posedge CLK21M or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= NORMAL;
      GRANT       <= G_IDLE;
      GRANT_VALID <= 1'b0;
      STARVE_CNT  <= 4'd0;
      CPU_WR_ACK  <= 1'b0;
      CPU_RD_ACK  <= 1'b0;
      CMD_WR_ACK  <= 1'b0;
      CMD_RD_ACK  <= 1'b0;
    end else if (slot) begin
      state       <= state_nxt;
      GRANT       <= grant_nxt;
      GRANT_VALID <= 1'b1;
      STARVE_CNT  <= cnt_nxt;
      if (grant_nxt == G_CPUW) CPU_WR_ACK <= ~CPU_WR_ACK;
      if (grant_nxt == G_CPUR) CPU_RD_ACK <= ~CPU_RD_ACK;
      if (grant_nxt == G_VDPW) CMD_WR_ACK <= ~CMD_WR_ACK;
      if (grant_nxt == G_VDPR) CMD_RD_ACK <= ~CMD_RD_ACK;
    end else begin
      GRANT_VALID <= 1'b0;
    end
  end
endmodule

// File: doc/vram_slot_scheduler.md
VRAM_SLOT_SCHEDULER -- requirements
Module: vram_slot_scheduler

Interface
REQ-001 Parameter STARVE_LIMIT, default 8: number of consecutive denied arbitration slots with a command access pending before command boost; legal range 1..15.
REQ-002 CLK21M  input  1  system clock, all state on rising edge.
REQ-003 RESET_N  input  1  asynchronous, active-low reset.
REQ-004 DOTSTATE  input  2  dot phase; 2'b10 marks an arbitration slot.
REQ-005 DISP_RSV  input  1  display fetch reserves the current slot.
REQ-006 SPRT_RSV  input  1  sprite fetch reserves the current slot.
REQ-007 CPU_WR_REQ  input  1  CPU write request, toggle protocol.
REQ-008 CPU_RD_REQ  input  1  CPU read request, toggle protocol.
REQ-009 CMD_ACTIVE  input  1  VDP command engine running.
REQ-010 CMD_WR_REQ  input  1  command write request, toggle protocol.
REQ-011 CMD_RD_REQ  input  1  command read request, toggle protocol.
REQ-012 CPU_WR_ACK, CPU_RD_ACK, CMD_WR_ACK, CMD_RD_ACK  output  1 each  toggle acknowledges.
REQ-013 GRANT  output  3  registered grant code: 0 IDLE, 1 DRAW, 2 CPUW, 3 CPUR, 4 SPRT, 5 VDPW, 6 VDPR, 7 VDPS.
REQ-014 GRANT_VALID  output  1  one-cycle pulse marking a new GRANT.
REQ-015 CMD_BOOST  output  1  high while the boost state is active.
REQ-016 STARVE_CNT  output  4  current denied-slot count.

Function
REQ-017 A request is pending when its REQ differs from its ACK; command requests count as pending only while CMD_ACTIVE=1.
REQ-018 Arbitration is evaluated only on cycles with DOTSTATE=2'b10; on every other cycle GRANT_VALID=0, GRANT holds, and all ACKs, counter and state hold.
REQ-019 Normal priority: DISP_RSV -> DRAW; else SPRT_RSV -> SPRT; else CPU write -> CPUW; else CPU read -> CPUR; else command write -> VDPW; else command read -> VDPR; else CMD_ACTIVE -> VDPS; else IDLE.
REQ-020 FSM has two states, NORMAL and BOOST; in BOOST a pending command write, or else a pending command read, ranks directly after SPRT and above both CPU requests.
REQ-021 DISP_RSV and SPRT_RSV are never overridden, in either state.
REQ-022 Latency: GRANT, GRANT_VALID=1 and the single matching ACK toggle all update on the clock edge that samples DOTSTATE=2'b10.
REQ-023 At most one ACK toggles per slot; DRAW, SPRT, VDPS and IDLE toggle no ACK.
REQ-024 STARVE_CNT, evaluated per slot: cleared on a VDPW/VDPR grant, and cleared when no command request is pending.
REQ-025 Otherwise STARVE_CNT increments by 1 and saturates at STARVE_LIMIT.
REQ-026 NORMAL->BOOST on the slot where STARVE_CNT becomes STARVE_LIMIT.
REQ-027 BOOST->NORMAL on the slot that grants VDPW/VDPR, or when no command request is pending; STARVE_CNT is cleared on either exit.
REQ-028 CMD_BOOST=1 exactly when the state is BOOST.
REQ-029 CMD_ACTIVE falling forces NORMAL and STARVE_CNT=0 at the next slot; unacknowledged command toggles remain unacknowledged.
REQ-030 Requests toggled twice between slots (REQ equal to ACK again) are not pending; no grant is issued for them.

Reset
REQ-031 While RESET_N=0, all outputs are held at reset values: all ACKs 0, GRANT=0, GRANT_VALID=0, CMD_BOOST=0, STARVE_CNT=0, and state NORMAL.
REQ-032 Reset asserted mid-slot aborts that slot; no ACK toggles on that edge.
REQ-033 After reset release, any REQ already at 1 is pending and is served at the first slot.

Verification
REQ-034 Slot with DISP_RSV=1 and CPU_WR_REQ toggled -> GRANT=1, CPU_WR_ACK unchanged; next slot with DISP_RSV=0 -> GRANT=2, CPU_WR_ACK toggles.
REQ-035 CPU_WR and CPU_RD both pending -> slot n GRANT=2, slot n+1 GRANT=3, each ACK toggles once.
REQ-036 STARVE_LIMIT=8, CMD_ACTIVE=1, CMD_WR pending, CPU_WR re-toggled every slot -> 8 CPUW grants with STARVE_CNT 1..8 and CMD_BOOST=1; 9th slot GRANT=5, CMD_WR_ACK toggles, STARVE_CNT=0, CMD_BOOST=0.
REQ-037 BOOST with SPRT_RSV=1 -> GRANT=4; command is still pending and CMD_BOOST stays 1.
REQ-038 CMD_ACTIVE=0 with CMD_RD pending, no CPU request -> GRANT=0, CMD_RD_ACK unchanged, STARVE_CNT=0.
REQ-039 RESET_N pulsed low during BOOST with STARVE_CNT=8 -> all outputs 0 immediately; CPU_WR_REQ=1 at release -> first slot GRANT=2.
